// File: rtl/bp_cache_req_arbiter.sv
// bp_cache_req_arbiter
// Shares one cache-miss request channel between the I$ (port 0) and the
// D$ (port 1). A winner is chosen while idle, its request is passed through
// combinationally, the owner's metadata follows in META, and the grant is
// held until the downstream completion pulse, which is routed back to the
// owner in the same cycle.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   icache_req_*              I$ request/valid/ready, metadata/valid, complete
//   dcache_req_*              D$ request/valid/ready, metadata/valid, complete
//   req_o/req_v_o/req_ready_i shared downstream request channel
//   req_metadata_o/_v_o       shared downstream metadata
//   req_complete_i            downstream completion pulse
//   grant_id_o                current/last owner (0 = I$, 1 = D$)
//   busy_o                    high while a request is outstanding
//
// Configuration macro:
//   BP_CACHE_REQ_ARB_DCACHE_PRIORITY_EN  defined -> D$ always wins a tie
//                                        undefined -> round-robin
module bp_cache_req_arbiter #(
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [req_width_p-1:0]      icache_req_i,
  input  logic                        icache_req_v_i,
  output logic                        icache_req_ready_o,
  input  logic [metadata_width_p-1:0] icache_req_metadata_i,
  input  logic                        icache_req_metadata_v_i,
  output logic                        icache_req_complete_o,
  input  logic [req_width_p-1:0]      dcache_req_i,
  input  logic                        dcache_req_v_i,
  output logic                        dcache_req_ready_o,
  input  logic [metadata_width_p-1:0] dcache_req_metadata_i,
  input  logic                        dcache_req_metadata_v_i,
  output logic                        dcache_req_complete_o,
  output logic [req_width_p-1:0]      req_o,
  output logic                        req_v_o,
  input  logic                        req_ready_i,
  output logic [metadata_width_p-1:0] req_metadata_o,
  output logic                        req_metadata_v_o,
  input  logic                        req_complete_i,
  output logic                        grant_id_o,
  output logic                        busy_o
);

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_meta = 2'd1,
    e_busy = 2'd2
  } state_e;

  state_e r_state;
  logic   r_grant_id;
  logic   r_busy;

  logic w_idle;
  logic w_tie_winner;
  logic w_winner;
  logic w_handshake;
  logic w_owner_meta_v;
  logic w_complete;

`ifdef BP_CACHE_REQ_ARB_DCACHE_PRIORITY_EN
  assign w_tie_winner = 1'b1;
`else
  // Points at the requester that wins the next tie: the one that did not
  // own the last accepted grant.
  logic r_rr_favour;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      r_rr_favour <= 1'b0;
    else if (w_handshake)
      r_rr_favour <= ~w_winner;
  end

  assign w_tie_winner = r_rr_favour;
`endif

  assign w_idle = (r_state == e_idle);

  // With a single valid requester it wins outright; with none the choice
  // is irrelevant because req_v_o is low.
  assign w_winner = (icache_req_v_i & dcache_req_v_i) ? w_tie_winner : dcache_req_v_i;

  assign req_o       = w_winner ? dcache_req_i : icache_req_i;
  assign req_v_o     = w_idle & (icache_req_v_i | dcache_req_v_i);
  assign w_handshake = req_v_o & req_ready_i;

  assign icache_req_ready_o = w_idle & ~w_winner & req_ready_i;
  assign dcache_req_ready_o = w_idle &  w_winner & req_ready_i;

  // Only the owner's metadata is visible; the other side's valid is ignored.
  assign req_metadata_o   = r_grant_id ? dcache_req_metadata_i : icache_req_metadata_i;
  assign w_owner_meta_v   = r_grant_id ? dcache_req_metadata_v_i : icache_req_metadata_v_i;
  assign req_metadata_v_o = (r_state == e_meta) & w_owner_meta_v;

  // A completion is only meaningful while a request is outstanding.
  assign w_complete            = ~w_idle & req_complete_i;
  assign icache_req_complete_o = w_complete & ~r_grant_id;
  assign dcache_req_complete_o = w_complete &  r_grant_id;

  assign grant_id_o = r_grant_id;
  assign busy_o     = r_busy;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= e_idle;
      r_grant_id <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        e_idle: begin
          if (w_handshake) begin
            r_state    <= e_meta;
            r_grant_id <= w_winner;
            r_busy     <= 1'b1;
          end
        end
        e_meta: begin
          // An early completion takes precedence over the metadata beat.
          if (req_complete_i) begin
            r_state <= e_idle;
            r_busy  <= 1'b0;
          end else if (w_owner_meta_v) begin
            r_state <= e_busy;
          end
        end
        e_busy: begin
          if (req_complete_i) begin
            r_state <= e_idle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= e_idle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A completion with nothing outstanding is dropped; flag it so a stray
  // pulse from downstream is visible in simulation.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      a_no_idle_complete: assert (!(w_idle && req_complete_i))
        else $warning("bp_cache_req_arbiter: req_complete_i while idle, ignored");
    end
  end
`endif

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
module tb_bp_cache_req_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] icache_req_i, dcache_req_i, req_o;
  logic        icache_req_v_i, dcache_req_v_i;
  logic        icache_req_ready_o, dcache_req_ready_o;
  logic [7:0]  icache_req_metadata_i, dcache_req_metadata_i, req_metadata_o;
  logic        icache_req_metadata_v_i, dcache_req_metadata_v_i;
  logic        icache_req_complete_o, dcache_req_complete_o;
  logic        req_v_o, req_ready_i, req_metadata_v_o, req_complete_i;
  logic        grant_id_o, busy_o;

  int total = 0;
  int bad   = 0;

`ifdef BP_CACHE_REQ_ARB_DCACHE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  bp_cache_req_arbiter #(.req_width_p(64), .metadata_width_p(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .icache_req_i(icache_req_i), .icache_req_v_i(icache_req_v_i),
    .icache_req_ready_o(icache_req_ready_o),
    .icache_req_metadata_i(icache_req_metadata_i),
    .icache_req_metadata_v_i(icache_req_metadata_v_i),
    .icache_req_complete_o(icache_req_complete_o),
    .dcache_req_i(dcache_req_i), .dcache_req_v_i(dcache_req_v_i),
    .dcache_req_ready_o(dcache_req_ready_o),
    .dcache_req_metadata_i(dcache_req_metadata_i),
    .dcache_req_metadata_v_i(dcache_req_metadata_v_i),
    .dcache_req_complete_o(dcache_req_complete_o),
    .req_o(req_o), .req_v_o(req_v_o), .req_ready_i(req_ready_i),
    .req_metadata_o(req_metadata_o), .req_metadata_v_o(req_metadata_v_o),
    .req_complete_i(req_complete_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Returns 1 time unit after a rising edge, so inputs change away from it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    icache_req_i = '0; icache_req_v_i = 1'b0;
    icache_req_metadata_i = '0; icache_req_metadata_v_i = 1'b0;
    dcache_req_i = '0; dcache_req_v_i = 1'b0;
    dcache_req_metadata_i = '0; dcache_req_metadata_v_i = 1'b0;
    req_ready_i = 1'b0; req_complete_i = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    tick();
  endtask

  // Stimulus only: metadata beat from the owner, then completion.
  task automatic finish_txn(input bit owner);
    if (owner) dcache_req_metadata_v_i = 1'b1; else icache_req_metadata_v_i = 1'b1;
    tick();
    icache_req_metadata_v_i = 1'b0; dcache_req_metadata_v_i = 1'b0;
    req_complete_i = 1'b1;
    tick();
    req_complete_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_i = 1'b1;
    tick();
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (grant_id_o !== 1'b0) begin bad++; $display("FAIL reset_grant: got %b want 0", grant_id_o); end
    total++; if (req_v_o !== 1'b0) begin bad++; $display("FAIL reset_req_v: got %b want 0", req_v_o); end
    total++; if (req_metadata_v_o !== 1'b0) begin bad++; $display("FAIL reset_meta_v: got %b want 0", req_metadata_v_o); end
    total++; if ({icache_req_complete_o, dcache_req_complete_o} !== 2'b00) begin bad++; $display("FAIL reset_complete: got %b want 00", {icache_req_complete_o, dcache_req_complete_o}); end
    reset_i = 1'b0;
    tick();
    $display("txn reset: done");
  endtask

  task automatic test_single_icache();
    apply_reset();
    icache_req_i = 64'h1000; icache_req_v_i = 1'b1; icache_req_metadata_i = 8'h3; req_ready_i = 1'b1;
    #1; // cycle 0
    total++; if (icache_req_ready_o !== 1'b1) begin bad++; $display("FAIL single_iready: got %b want 1", icache_req_ready_o); end
    total++; if (dcache_req_ready_o !== 1'b0) begin bad++; $display("FAIL single_dready: got %b want 0", dcache_req_ready_o); end
    total++; if (req_o !== 64'h1000) begin bad++; $display("FAIL single_req: got %h want 1000", req_o); end
    total++; if (req_v_o !== 1'b1) begin bad++; $display("FAIL single_req_v: got %b want 1", req_v_o); end
    tick(); // cycle 1, META
    icache_req_v_i = 1'b0; icache_req_metadata_v_i = 1'b1;
    #1;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy_o); end
    total++; if (icache_req_ready_o !== 1'b0) begin bad++; $display("FAIL single_iready_meta: got %b want 0", icache_req_ready_o); end
    total++; if (req_metadata_v_o !== 1'b1) begin bad++; $display("FAIL single_meta_v: got %b want 1", req_metadata_v_o); end
    total++; if (req_metadata_o !== 8'h3) begin bad++; $display("FAIL single_meta: got %h want 03", req_metadata_o); end
    tick(); // cycle 2, BUSY
    icache_req_metadata_v_i = 1'b0;
    #1;
    total++; if (req_metadata_v_o !== 1'b0) begin bad++; $display("FAIL single_meta_v_busy: got %b want 0", req_metadata_v_o); end
    tick(); // cycle 3
    tick(); // cycle 4
    req_complete_i = 1'b1;
    #1;
    total++; if (icache_req_complete_o !== 1'b1) begin bad++; $display("FAIL single_icomplete: got %b want 1", icache_req_complete_o); end
    total++; if (dcache_req_complete_o !== 1'b0) begin bad++; $display("FAIL single_dcomplete: got %b want 0", dcache_req_complete_o); end
    tick();
    req_complete_i = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", busy_o); end
    total++; if (icache_req_complete_o !== 1'b0) begin bad++; $display("FAIL single_pulse_len: got %b want 0", icache_req_complete_o); end
    $display("txn single_icache: req=1000 meta=3 done");
  endtask

  task automatic test_arbitration();
    bit exp;
    apply_reset();
    icache_req_i = 64'h1111; dcache_req_i = 64'h2222;
    icache_req_metadata_i = 8'h11; dcache_req_metadata_i = 8'h22;
    icache_req_v_i = 1'b1; dcache_req_v_i = 1'b1; req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = PRIO ? 1'b1 : i[0];
      #1;
      total++; if (dcache_req_ready_o !== exp) begin bad++; $display("FAIL arb_dready[%0d]: got %b want %b", i, dcache_req_ready_o, exp); end
      total++; if (icache_req_ready_o !== ~exp) begin bad++; $display("FAIL arb_iready[%0d]: got %b want %b", i, icache_req_ready_o, ~exp); end
      total++; if (req_o !== (exp ? 64'h2222 : 64'h1111)) begin bad++; $display("FAIL arb_req[%0d]: got %h", i, req_o); end
      tick();
      total++; if (grant_id_o !== exp) begin bad++; $display("FAIL arb_grant[%0d]: got %b want %b", i, grant_id_o, exp); end
      if (exp) dcache_req_metadata_v_i = 1'b1; else icache_req_metadata_v_i = 1'b1;
      #1;
      total++; if (req_metadata_o !== (exp ? 8'h22 : 8'h11)) begin bad++; $display("FAIL arb_meta[%0d]: got %h", i, req_metadata_o); end
      tick();
      icache_req_metadata_v_i = 1'b0; dcache_req_metadata_v_i = 1'b0;
      req_complete_i = 1'b1;
      #1;
      total++; if ({dcache_req_complete_o, icache_req_complete_o} !== (exp ? 2'b10 : 2'b01)) begin bad++; $display("FAIL arb_complete[%0d]: got %b", i, {dcache_req_complete_o, icache_req_complete_o}); end
      // Complete and pending request together: no acceptance this cycle.
      total++; if ({icache_req_ready_o, dcache_req_ready_o} !== 2'b00) begin bad++; $display("FAIL arb_ready_on_complete[%0d]: got %b want 00", i, {icache_req_ready_o, dcache_req_ready_o}); end
      tick();
      req_complete_i = 1'b0;
      $display("txn arbitration[%0d]: grant=%0d", i, exp);
    end
    clear_inputs();
  endtask

  task automatic test_ready_low();
    logic [63:0] exp_req;
    apply_reset();
    icache_req_v_i = 1'b1; req_ready_i = 1'b1;
    tick();
    icache_req_v_i = 1'b0;
    finish_txn(1'b0); // last owner I$ -> round-robin now favours D$
    req_ready_i = 1'b0;
    icache_req_i = 64'hAAAA_0000; icache_req_v_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin dcache_req_i = 64'hBBBB_0000; dcache_req_v_i = 1'b1; end
      exp_req = (c >= 3) ? 64'hBBBB_0000 : 64'hAAAA_0000;
      #1;
      total++; if (req_o !== exp_req) begin bad++; $display("FAIL rdylow_req[%0d]: got %h want %h", c, req_o, exp_req); end
      total++; if ({icache_req_ready_o, dcache_req_ready_o} !== 2'b00) begin bad++; $display("FAIL rdylow_ready[%0d]: got %b want 00", c, {icache_req_ready_o, dcache_req_ready_o}); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rdylow_busy[%0d]: got %b want 0", c, busy_o); end
      tick();
    end
    req_ready_i = 1'b1;
    #1;
    total++; if (dcache_req_ready_o !== 1'b1) begin bad++; $display("FAIL rdylow_dready: got %b want 1", dcache_req_ready_o); end
    tick();
    total++; if (grant_id_o !== 1'b1) begin bad++; $display("FAIL rdylow_grant: got %b want 1", grant_id_o); end
    icache_req_v_i = 1'b0; dcache_req_v_i = 1'b0;
    finish_txn(1'b1);
    $display("txn ready_low: accepted D$ after 5 stalled cycles");
  endtask

  task automatic test_meta_owner();
    apply_reset();
    icache_req_v_i = 1'b1; req_ready_i = 1'b1;
    tick();
    icache_req_v_i = 1'b0;
    dcache_req_metadata_v_i = 1'b1; dcache_req_metadata_i = 8'h55;
    icache_req_metadata_i = 8'h07;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (req_metadata_v_o !== 1'b0) begin bad++; $display("FAIL meta_nonowner_v[%0d]: got %b want 0", c, req_metadata_v_o); end
      total++; if (req_metadata_o !== 8'h07) begin bad++; $display("FAIL meta_nonowner_data[%0d]: got %h want 07", c, req_metadata_o); end
      tick();
    end
    icache_req_metadata_v_i = 1'b1;
    #1;
    total++; if (req_metadata_v_o !== 1'b1) begin bad++; $display("FAIL meta_owner_v: got %b want 1", req_metadata_v_o); end
    tick();
    icache_req_metadata_v_i = 1'b0; dcache_req_metadata_v_i = 1'b0;
    #1;
    total++; if (req_metadata_v_o !== 1'b0) begin bad++; $display("FAIL meta_after_busy: got %b want 0", req_metadata_v_o); end
    req_complete_i = 1'b1;
    tick();
    req_complete_i = 1'b0;
    $display("txn meta_owner: D$ metadata ignored while I$ owns");
  endtask

  task automatic test_idle_complete();
    apply_reset();
    req_complete_i = 1'b1;
    #1;
    total++; if ({icache_req_complete_o, dcache_req_complete_o} !== 2'b00) begin bad++; $display("FAIL idle_complete: got %b want 00", {icache_req_complete_o, dcache_req_complete_o}); end
    tick();
    req_complete_i = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_complete_busy: got %b want 0", busy_o); end
    $display("txn idle_complete: ignored");
  endtask

  task automatic test_reset_in_busy();
    apply_reset();
    dcache_req_v_i = 1'b1; req_ready_i = 1'b1;
    tick();
    dcache_req_v_i = 1'b0; dcache_req_metadata_v_i = 1'b1;
    tick();
    dcache_req_metadata_v_i = 1'b0;
    #1;
    total++; if ({busy_o, grant_id_o} !== 2'b11) begin bad++; $display("FAIL rstbusy_pre: got %b want 11", {busy_o, grant_id_o}); end
    reset_i = 1'b1;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstbusy_busy: got %b want 0", busy_o); end
    total++; if (grant_id_o !== 1'b0) begin bad++; $display("FAIL rstbusy_grant: got %b want 0", grant_id_o); end
    tick();
    reset_i = 1'b0;
    req_complete_i = 1'b1;
    #1;
    total++; if ({icache_req_complete_o, dcache_req_complete_o} !== 2'b00) begin bad++; $display("FAIL rstbusy_complete: got %b want 00", {icache_req_complete_o, dcache_req_complete_o}); end
    tick();
    req_complete_i = 1'b0;
    // Leave the round-robin pointer favouring D$, then reset mid-META.
    icache_req_v_i = 1'b1;
    tick();
    icache_req_v_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    icache_req_v_i = 1'b1; dcache_req_v_i = 1'b1;
    #1;
    total++; if (icache_req_ready_o !== ~PRIO) begin bad++; $display("FAIL rstbusy_tie_i: got %b want %b", icache_req_ready_o, ~PRIO); end
    total++; if (dcache_req_ready_o !== PRIO) begin bad++; $display("FAIL rstbusy_tie_d: got %b want %b", dcache_req_ready_o, PRIO); end
    clear_inputs();
    tick();
    $display("txn reset_in_busy: done");
  endtask

  initial begin
    reset_i = 1'b1;
    clear_inputs();
    test_reset();
    test_single_icache();
    test_arbitration();
    test_ready_low();
    test_meta_owner();
    test_idle_complete();
    test_reset_in_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
